// File: rtl/rc4_crack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_crack_pkg
//  Purpose  : Shared constants and types for the parallel RC4 key search.
//             Key width and key-space bound, the key type, and the state
//             encoding of the key-space dispatcher.
//  Revision : 1.0  initial release
// ============================================================================
package rc4_crack_pkg;

    localparam int NUM_CORES = 4;
    localparam int KEY_W     = 24;

    // 22-bit search space carried in a 24-bit key; top bits stay zero.
    localparam logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF;

    typedef logic [KEY_W-1:0] key_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPATCH = 3'd1,
        DRAIN    = 3'd2,
        HALT     = 3'd3,
        DONE     = 3'd4
    } dispatch_state_e;

    // Search is in progress (keys outstanding or being handed out).
    function automatic logic is_active(input dispatch_state_e s);
        return (s == DISPATCH) || (s == DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_space_dispatcher_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : N-way round-robin arbiter. Combinational one-hot grant that
//             searches upward from a registered pointer; the pointer moves to
//             one past the granted requester whenever the grant is taken.
//  Ports    : clk, reset   - clock, synchronous active-high reset
//             i_req[N]     - request vector
//             i_advance    - grant is consumed this cycle; move pointer
//             o_grant[N]   - one-hot grant (zero when no request)
//             o_any        - at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant,
    output logic         o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan candidates ptr, ptr+1, ... wrapping at N; first hit wins.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                w_idx           = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance && o_any) begin
            r_ptr <= (w_idx == IDX_W'(N-1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_space_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : key_space_dispatcher
//  Purpose  : Hands consecutive candidate keys 0..KEY_MAX to NUM_CORES cracking
//             cores over a per-core req/valid handshake, at most one grant per
//             cycle, round-robin. Freezes everything on stop_search and flags
//             exhaustion once the key space is used up with no key found.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             start             - begin search from key 0 (IDLE/DONE only)
//             stop_search       - key found elsewhere; level
//             core_req[N]       - core ready for a new key
//             core_key_valid[N] - 1-cycle pulse, core_key[i] valid
//             core_key[N]       - key assigned to each core
//             core_halt         - HALT or DONE
//             busy              - DISPATCH or DRAIN
//             exhausted         - key space finished, nothing found (sticky)
//             keys_issued       - keys handed out since start
//             search_cycles     - (stats) cycles spent in DISPATCH+DRAIN
//             core_grants[N]    - (stats) keys handed to each core
//  Config   : KEY_DISPATCH_STATS_EN adds the statistics outputs/counters.
//  Revision : 1.0  initial release
// ============================================================================
module key_space_dispatcher #(
    parameter int               NUM_CORES = rc4_crack_pkg::NUM_CORES,
    parameter int               KEY_W     = rc4_crack_pkg::KEY_W,
    parameter logic [KEY_W-1:0] KEY_MAX   = KEY_W'(rc4_crack_pkg::KEY_MAX)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stop_search,
    input  logic [NUM_CORES-1:0]              core_req,
    output logic [NUM_CORES-1:0]              core_key_valid,
    output logic [NUM_CORES-1:0][KEY_W-1:0]   core_key,
    output logic                              core_halt,
    output logic                              busy,
    output logic                              exhausted,
`ifdef KEY_DISPATCH_STATS_EN
    output logic [31:0]                       search_cycles,
    output logic [KEY_W-1:0]                  core_grants [NUM_CORES],
`endif
    output logic [KEY_W:0]                    keys_issued
);

    import rc4_crack_pkg::*;

    dispatch_state_e                  r_state;
    dispatch_state_e                  w_state_next;
    logic [KEY_W-1:0]                 r_next_key;
    logic [KEY_W:0]                   r_keys_issued;
    logic                             r_exhausted;
    logic [NUM_CORES-1:0]             r_valid;
    logic [NUM_CORES-1:0][KEY_W-1:0]  r_core_key;

    logic [NUM_CORES-1:0]             w_eligible;
    logic [NUM_CORES-1:0]             w_grant;
    logic                             w_any;
    logic                             w_grant_en;
    logic                             w_start_ok;
    logic                             w_all_idle;
    logic                             w_last_key;

    // A core whose key is being presented this cycle still shows req; mask it
    // so it cannot be granted twice for one request.
    assign w_eligible = core_req & ~r_valid;
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_all_idle = &core_req;
    assign w_last_key = (r_next_key == KEY_MAX);
    // stop_search beats a pending grant in the same cycle.
    assign w_grant_en = (r_state == DISPATCH) && !stop_search && w_any;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_eligible),
        .i_advance (w_grant_en),
        .o_grant   (w_grant),
        .o_any     (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = DISPATCH;
            end
            DISPATCH: begin
                if (stop_search)                  w_state_next = HALT;
                else if (w_grant_en && w_last_key) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (stop_search)     w_state_next = HALT;
                else if (w_all_idle) w_state_next = DONE;
            end
            HALT: begin
                w_state_next = HALT;
            end
            DONE: begin
                if (start) w_state_next = DISPATCH;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_next_key    <= '0;
            r_keys_issued <= '0;
            r_exhausted   <= 1'b0;
            r_valid       <= '0;
            r_core_key    <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_grant_en ? w_grant : '0;

            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_grant_en && w_grant[i]) begin
                    r_core_key[i] <= r_next_key;
                end
            end

            if (w_start_ok) begin
                r_next_key    <= '0;
                r_keys_issued <= '0;
                r_exhausted   <= 1'b0;
            end else if (w_grant_en) begin
                // Saturate at KEY_MAX: the counter never wraps back to 0.
                if (!w_last_key) begin
                    r_next_key <= r_next_key + 1'b1;
                end
                r_keys_issued <= r_keys_issued + (KEY_W+1)'(1);
            end

            if ((r_state == DRAIN) && !stop_search && w_all_idle) begin
                r_exhausted <= 1'b1;
            end
        end
    end

`ifdef KEY_DISPATCH_STATS_EN
    logic [31:0]      r_search_cycles;
    logic [KEY_W-1:0] r_core_grants [NUM_CORES];

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_search_cycles <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_core_grants[i] <= '0;
            end
        end else begin
            if (is_active(r_state)) begin
                r_search_cycles <= r_search_cycles + 32'd1;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_grant_en && w_grant[i]) begin
                    r_core_grants[i] <= r_core_grants[i] + 1'b1;
                end
            end
        end
    end

    assign search_cycles = r_search_cycles;
    assign core_grants   = r_core_grants;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign core_key_valid = r_valid;
    assign core_key       = r_core_key;
    assign core_halt      = (r_state == HALT) || (r_state == DONE);
    assign busy           = is_active(r_state);
    assign exhausted      = r_exhausted;
    assign keys_issued    = r_keys_issued;

endmodule
`default_nettype wire

// File: tb/tb_key_space_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_space_dispatcher
//  Purpose  : Directed, self-checking bench for key_space_dispatcher. A full
//             key-space instance and a KEY_MAX=7 instance; expected grants are
//             queued when stimulus is driven and popped as valids appear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_space_dispatcher;

    typedef struct packed {
        logic [7:0]  core;
        logic [23:0] key;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q7[$];

    // Default-size instance
    logic             reset, start, stop_search;
    logic [3:0]       core_req;
    logic [3:0]       core_key_valid;
    logic [3:0][23:0] core_key;
    logic             core_halt, busy, exhausted;
    logic [24:0]      keys_issued;

    // KEY_MAX = 7 instance
    logic             rst7, start7, stop7;
    logic [3:0]       req7;
    logic [3:0]       valid7;
    logic [3:0][23:0] key7;
    logic             halt7, busy7, exh7;
    logic [24:0]      issued7;

`ifdef KEY_DISPATCH_STATS_EN
    logic [31:0] search_cycles, search_cycles7;
    logic [23:0] core_grants  [4];
    logic [23:0] core_grants7 [4];
`endif

    key_space_dispatcher dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop_search    (stop_search),
        .core_req       (core_req),
        .core_key_valid (core_key_valid),
        .core_key       (core_key),
        .core_halt      (core_halt),
        .busy           (busy),
        .exhausted      (exhausted),
`ifdef KEY_DISPATCH_STATS_EN
        .search_cycles  (search_cycles),
        .core_grants    (core_grants),
`endif
        .keys_issued    (keys_issued)
    );

    key_space_dispatcher #(.KEY_MAX(24'd7)) dut7 (
        .clk            (clk),
        .reset          (rst7),
        .start          (start7),
        .stop_search    (stop7),
        .core_req       (req7),
        .core_key_valid (valid7),
        .core_key       (key7),
        .core_halt      (halt7),
        .busy           (busy7),
        .exhausted      (exh7),
`ifdef KEY_DISPATCH_STATS_EN
        .search_cycles  (search_cycles7),
        .core_grants    (core_grants7),
`endif
        .keys_issued    (issued7)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int core, input int key);
        q0.push_back('{core: 8'(core), key: 24'(key)});
    endtask

    // Scoreboards: every valid pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (|core_key_valid) check("dut_single_grant", 64'($countones(core_key_valid)), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (core_key_valid[i]) begin
                check("dut_expected_valid", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    check("dut_grant_core", 64'(i), 64'(e.core));
                    check("dut_grant_key", 64'(core_key[i]), 64'(e.key));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (|valid7) check("dut7_single_grant", 64'($countones(valid7)), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (valid7[i]) begin
                check("dut7_expected_valid", 64'(q7.size() != 0), 64'd1);
                if (q7.size() != 0) begin
                    e = q7.pop_front();
                    check("dut7_grant_core", 64'(i), 64'(e.core));
                    check("dut7_grant_key", 64'(key7[i]), 64'(e.key));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop_search = 1'b0; core_req = 4'b0000;
        rst7  = 1'b1; start7 = 1'b0; stop7 = 1'b0; req7 = 4'b0000;

        // ---- Reset, with start coinciding with the final reset cycle ----
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_valid", 64'(core_key_valid), 64'd0);
        check("rst_key", 64'(core_key), 64'd0);
        check("rst_halt", 64'(core_halt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_exhausted", 64'(exhausted), 64'd0);
        check("rst_issued", 64'(keys_issued), 64'd0);
        check("rst7_issued", 64'(issued7), 64'd0);
        reset = 1'b0;
        tick();
        check("start_with_reset_ignored", 64'(busy), 64'd0);

        // ---- 1: all cores requesting, round-robin keys 0..4 ----
        push0(0, 0); push0(1, 1); push0(2, 2); push0(3, 3); push0(0, 4);
        start = 1'b1; core_req = 4'b1111;
        tick();
        start = 1'b0;
        check("s1_busy", 64'(busy), 64'd1);
        check("s1_no_early_valid", 64'(core_key_valid), 64'd0);
        repeat (5) tick();
        core_req = 4'b0000;
        repeat (2) tick();
        check("s1_issued", 64'(keys_issued), 64'd5);
        check("s1_sb_drained", 64'(q0.size()), 64'd0);

        // ---- 2: only core 2, no repeat grant in its valid cycle ----
        reset = 1'b1; tick(); reset = 1'b0;
        push0(2, 0); push0(2, 1); push0(2, 2);
        start = 1'b1; core_req = 4'b0100;
        tick();
        start = 1'b0;
        tick();
        check("s2_valid_a", 64'(core_key_valid), 64'h4);
        tick();
        check("s2_mask_a", 64'(core_key_valid), 64'd0);
        tick();
        check("s2_valid_b", 64'(core_key_valid), 64'h4);
        tick();
        check("s2_mask_b", 64'(core_key_valid), 64'd0);
        tick();
        core_req = 4'b0000;
        repeat (2) tick();
        check("s2_issued", 64'(keys_issued), 64'd3);
        check("s2_sb_drained", 64'(q0.size()), 64'd0);

        // ---- 3: KEY_MAX=7, exhaust the space ----
        rst7 = 1'b0;
        for (int i = 0; i < 8; i++) q7.push_back('{core: 8'(i % 4), key: 24'(i)});
        start7 = 1'b1; req7 = 4'b1111;
        tick();
        start7 = 1'b0;
        repeat (8) tick();
        check("s3_drain_busy", 64'(busy7), 64'd1);
        check("s3_drain_not_exh", 64'(exh7), 64'd0);
        check("s3_drain_issued", 64'(issued7), 64'd8);
        tick();
        check("s3_exhausted", 64'(exh7), 64'd1);
        check("s3_halt", 64'(halt7), 64'd1);
        check("s3_busy", 64'(busy7), 64'd0);
        check("s3_issued", 64'(issued7), 64'd8);
`ifdef KEY_DISPATCH_STATS_EN
        check("s6_search_cycles", 64'(search_cycles7), 64'd9);
        for (int i = 0; i < 4; i++) check("s6_core_grants", 64'(core_grants7[i]), 64'd2);
`endif
        repeat (3) tick();
        check("s3_still_exh", 64'(exh7), 64'd1);
        check("s3_sb_drained", 64'(q7.size()), 64'd0);
`ifdef KEY_DISPATCH_STATS_EN
        check("s6_search_frozen", 64'(search_cycles7), 64'd9);
`endif

        // ---- 4: stop_search in the cycle core 1 would get key 5 ----
        reset = 1'b1; tick(); reset = 1'b0;
        push0(0, 0); push0(1, 1); push0(2, 2); push0(3, 3); push0(0, 4);
        start = 1'b1; core_req = 4'b1111;
        tick();
        start = 1'b0;
        repeat (5) tick();
        stop_search = 1'b1;
        tick();
        check("s4_no_valid", 64'(core_key_valid), 64'd0);
        check("s4_halt", 64'(core_halt), 64'd1);
        check("s4_busy", 64'(busy), 64'd0);
        check("s4_issued", 64'(keys_issued), 64'd5);
        check("s4_exhausted", 64'(exhausted), 64'd0);
        repeat (3) tick();
        check("s4_issued_frozen", 64'(keys_issued), 64'd5);
        check("s4_sb_drained", 64'(q0.size()), 64'd0);
        stop_search = 1'b0; core_req = 4'b0000;

        // ---- 5: reset after 10 keys, then restart from key 0 ----
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 10; i++) push0(i % 4, i);
        start = 1'b1; core_req = 4'b1111;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("s5_issued_10", 64'(keys_issued), 64'd10);
        reset = 1'b1;
        tick();
        check("s5_rst_valid", 64'(core_key_valid), 64'd0);
        check("s5_rst_key", 64'(core_key), 64'd0);
        check("s5_rst_issued", 64'(keys_issued), 64'd0);
        check("s5_rst_busy", 64'(busy), 64'd0);
        check("s5_rst_halt", 64'(core_halt), 64'd0);
        reset = 1'b0;
        push0(0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        core_req = 4'b0000;
        repeat (2) tick();
        check("s5_restart_issued", 64'(keys_issued), 64'd1);
        check("s5_sb_drained", 64'(q0.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
